mc_control_unit: RTL

//  Multicycle control FSM for the 16-bit TSC CPU; drives the alu block from the issuing side.

---
 rtl/mc_control_unit_pkg.sv | 92 +++++++++
 rtl/mc_control_unit_instr_decoder.sv | 59 +++++
 rtl/mc_control_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the TSC multicycle control unit: opcodes, R-type function
// fields, ALU function codes, FSM states, instruction classes and datapath select codes.
package mc_control_unit_pkg;

   localparam int WORD_SIZE = 16;

   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   localparam logic [5:0] FN_ADD = 6'd0;
   localparam logic [5:0] FN_SUB = 6'd1;
   localparam logic [5:0] FN_AND = 6'd2;
   localparam logic [5:0] FN_ORR = 6'd3;
   localparam logic [5:0] FN_NOT = 6'd4;
   localparam logic [5:0] FN_TCP = 6'd5;
   localparam logic [5:0] FN_SHL = 6'd6;
   localparam logic [5:0] FN_SHR = 6'd7;
   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   localparam logic [3:0] FUNC_ADD = 4'd0;
   localparam logic [3:0] FUNC_SUB = 4'd1;
   localparam logic [3:0] FUNC_AND = 4'd2;
   localparam logic [3:0] FUNC_ORR = 4'd3;
   localparam logic [3:0] FUNC_NOT = 4'd4;
   localparam logic [3:0] FUNC_TCP = 4'd5;
   localparam logic [3:0] FUNC_SHL = 4'd6;
   localparam logic [3:0] FUNC_SHR = 4'd7;
   localparam logic [3:0] FUNC_LHI = 4'd8;
   localparam logic [3:0] FUNC_BNE = 4'd9;
   localparam logic [3:0] FUNC_BEQ = 4'd10;
   localparam logic [3:0] FUNC_BGZ = 4'd11;
   localparam logic [3:0] FUNC_BLZ = 4'd12;

   localparam logic [1:0] PC_NEXT   = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;

   localparam logic       SRC_A_RS = 1'b0;
   localparam logic       SRC_A_PC = 1'b1;

   localparam logic [1:0] SRC_B_RT   = 2'd0;
   localparam logic [1:0] SRC_B_SEXT = 2'd1;
   localparam logic [1:0] SRC_B_ZEXT = 2'd2;
   localparam logic [1:0] SRC_B_ONE  = 2'd3;

   localparam logic [1:0] DST_RT   = 2'd0;
   localparam logic [1:0] DST_RD   = 2'd1;
   localparam logic [1:0] DST_LINK = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      C_NOP    = 4'd0,
      C_ALU_R  = 4'd1,
      C_ALU_I  = 4'd2,
      C_LWD    = 4'd3,
      C_SWD    = 4'd4,
      C_BRANCH = 4'd5,
      C_JMP    = 4'd6,
      C_JAL    = 4'd7,
      C_JPR    = 4'd8,
      C_JRL    = 4'd9,
      C_WWD    = 4'd10,
      C_HLT    = 4'd11
   } instr_class_e;

endpackage

// File: rtl/mc_control_unit_instr_decoder.sv
// Combinational instruction decode: classifies the IR contents and selects the EX-stage
// ALU function and operand-B source. Register fields are consumed by the datapath, not here.
module instr_decoder
   import mc_control_unit_pkg::*;
#(
   parameter int WORD_SIZE = 16
) (
   input  logic [WORD_SIZE-1:0] instr,
   output logic [3:0]           instrClass,
   output logic [3:0]           funcCode,
   output logic [1:0]           aluSrcB
);

   logic [3:0] opcode;
   logic [5:0] func;
   logic       unusedFields;

   assign opcode       = instr[WORD_SIZE-1 -: 4];
   assign func         = instr[5:0];
   assign unusedFields = ^instr[WORD_SIZE-5:6];

   always_comb begin
      instrClass = C_NOP;
      funcCode   = FUNC_ADD;
      aluSrcB    = SRC_B_RT;
      case (opcode)
         OP_BNE: begin instrClass = C_BRANCH; funcCode = FUNC_BNE; end
         OP_BEQ: begin instrClass = C_BRANCH; funcCode = FUNC_BEQ; end
         OP_BGZ: begin instrClass = C_BRANCH; funcCode = FUNC_BGZ; end
         OP_BLZ: begin instrClass = C_BRANCH; funcCode = FUNC_BLZ; end
         OP_ADI: begin instrClass = C_ALU_I; funcCode = FUNC_ADD; aluSrcB = SRC_B_SEXT; end
         OP_ORI: begin instrClass = C_ALU_I; funcCode = FUNC_ORR; aluSrcB = SRC_B_ZEXT; end
         OP_LHI: begin instrClass = C_ALU_I; funcCode = FUNC_LHI; aluSrcB = SRC_B_ZEXT; end
         OP_LWD: begin instrClass = C_LWD; funcCode = FUNC_ADD; aluSrcB = SRC_B_SEXT; end
         OP_SWD: begin instrClass = C_SWD; funcCode = FUNC_ADD; aluSrcB = SRC_B_SEXT; end
         OP_JMP: instrClass = C_JMP;
         OP_JAL: instrClass = C_JAL;
         OP_RTYPE: begin
            case (func)
               FN_ADD: begin instrClass = C_ALU_R; funcCode = FUNC_ADD; end
               FN_SUB: begin instrClass = C_ALU_R; funcCode = FUNC_SUB; end
               FN_AND: begin instrClass = C_ALU_R; funcCode = FUNC_AND; end
               FN_ORR: begin instrClass = C_ALU_R; funcCode = FUNC_ORR; end
               FN_NOT: begin instrClass = C_ALU_R; funcCode = FUNC_NOT; end
               FN_TCP: begin instrClass = C_ALU_R; funcCode = FUNC_TCP; end
               FN_SHL: begin instrClass = C_ALU_R; funcCode = FUNC_SHL; end
               FN_SHR: begin instrClass = C_ALU_R; funcCode = FUNC_SHR; end
               FN_JPR: instrClass = C_JPR;
               FN_JRL: instrClass = C_JRL;
               FN_WWD: instrClass = C_WWD;
               FN_HLT: instrClass = C_HLT;
               default: instrClass = C_NOP;
            endcase
         end
         default: instrClass = C_NOP;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle IF/ID/EX/MEM/WB control FSM for the 16-bit TSC CPU.
// Define INST_COUNTER_EN to build the retired-instruction counter on num_inst.
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int WORD_SIZE = mc_control_unit_pkg::WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 inputReady,
   input  logic                 bResult,
   output logic                 readM,
   output logic                 writeM,
   output logic                 addr_sel,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic [3:0]           funcCode,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic [1:0]           wb_src,
   output logic                 wwd_valid,
   output logic                 is_halted,
   output logic [15:0]          num_inst,
   output logic [2:0]           dbgState
);

   state_e     state, nextState;
   logic       running;
   logic [3:0] decClass;
   logic [3:0] decFunc;
   logic [1:0] decSrcB;

   instr_decoder #(.WORD_SIZE(WORD_SIZE)) uDecoder (
      .instr      (instr),
      .instrClass (decClass),
      .funcCode   (decFunc),
      .aluSrcB    (decSrcB)
   );

   // running stays low for the cycle after a reset edge so every output reads 0 there.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IF;
         running <= 1'b0;
      end else begin
         state   <= nextState;
         running <= 1'b1;
      end
   end

   assign dbgState = state;

   // Memory handshake: readM/writeM are held while in S_IF/S_MEM until the cycle in
   // which inputReady is seen; the request drops the following cycle with the state change.
   always_comb begin
      nextState = state;
      readM     = 1'b0;
      writeM    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_NEXT;
      funcCode  = FUNC_ADD;
      alu_src_a = SRC_A_RS;
      alu_src_b = SRC_B_RT;
      reg_write = 1'b0;
      reg_dst   = DST_RT;
      wb_src    = WB_ALU;
      wwd_valid = 1'b0;
      is_halted = 1'b0;
      if (!running) begin
         nextState = S_IF;
      end else begin
         case (state)
            S_IF: begin
               readM = 1'b1;
               if (inputReady) begin
                  ir_write  = 1'b1;
                  nextState = S_ID;
               end
            end
            S_ID: begin
               alu_src_a = SRC_A_PC;
               alu_src_b = SRC_B_ONE;
               pc_write  = 1'b1;
               case (decClass)
                  C_JMP:   begin pc_src = PC_JUMP; nextState = S_IF; end
                  C_JAL:   begin pc_src = PC_JUMP; nextState = S_WB; end
                  C_HLT:   nextState = S_HALT;
                  C_NOP:   nextState = S_IF;
                  default: nextState = S_EX;
               endcase
            end
            S_EX: begin
               funcCode  = decFunc;
               alu_src_b = decSrcB;
               nextState = S_IF;
               case (decClass)
                  C_ALU_R, C_ALU_I: nextState = S_WB;
                  C_LWD, C_SWD:     nextState = S_MEM;
                  C_BRANCH: begin
                     if (bResult) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                     end
                  end
                  C_JPR: begin pc_write = 1'b1; pc_src = PC_REG; end
                  C_JRL: begin pc_write = 1'b1; pc_src = PC_REG; nextState = S_WB; end
                  C_WWD: wwd_valid = 1'b1;
                  default: ;
               endcase
            end
            S_MEM: begin
               addr_sel = 1'b1;
               readM    = (decClass == C_LWD);
               writeM   = (decClass == C_SWD);
               if (inputReady) nextState = (decClass == C_LWD) ? S_WB : S_IF;
            end
            S_WB: begin
               reg_write = 1'b1;
               nextState = S_IF;
               case (decClass)
                  C_ALU_R:      reg_dst = DST_RD;
                  C_LWD:        wb_src = WB_MEM;
                  C_JAL, C_JRL: begin reg_dst = DST_LINK; wb_src = WB_PC; end
                  default: ;
               endcase
            end
            S_HALT: is_halted = 1'b1;
            default: nextState = S_IF;
         endcase
      end
   end

`ifdef INST_COUNTER_EN
   logic [15:0] instCount;
   logic        retire;

   // An instruction retires when it leaves for S_IF, or once when HLT enters S_HALT.
   assign retire = running && (state != S_IF) && (state != S_HALT) &&
                   ((nextState == S_IF) || (nextState == S_HALT));

   always_ff @(posedge clk) begin
      if (!reset_n)    instCount <= 16'd0;
      else if (retire) instCount <= instCount + 16'd1;
   end

   assign num_inst = instCount;
`else
   assign num_inst = 16'd0;
`endif

endmodule
